mcu_cmd_seq: RTL and testbench
==============================

MCU_CMD_SEQ -- requirements
Module: mcu_cmd_seq

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning): MAX_BLK, 8, maximum BLK commands accepted per phase.
REQ-002 The block SHALL have the parameter PROC_CYC, 16, exact number of cycles spent in PROC (legal range 1..65535).
REQ-003 The block SHALL have the parameter CNT_W, 4, width of o_blk_cnt (2^CNT_W > MAX_BLK).
REQ-004 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-005 The block SHALL have the port clk, in, 1, rising-edge clock.
REQ-006 The block SHALL have the port rst, in, 1, asynchronous active-high reset.
REQ-007 The block SHALL have the port i_cmd_valid, in, 1, host command valid.
REQ-008 The block SHALL have the port i_cmd, in, 3, command code: 000 NOP, 001 BLK, 010 RUN, 011 NEXT, 100 CLR, others illegal.
REQ-009 The block SHALL have the port o_cmd_ready, out, 1, command can be accepted this cycle.
REQ-010 The block SHALL have the ports o_sop and o_eop, out, 1 each, phase code {o_eop,o_sop}: 00 LOAD, 01 PROC, 10 OUT; 11 never driven.
REQ-011 The block SHALL have the port o_chblk, out, 1, one-cycle block-change pulse to the memory control unit.
REQ-012 The block SHALL have the port o_blk_cnt, out, CNT_W, blocks accepted in the current phase.
REQ-013 The block SHALL have the port o_err, out, 1, sticky illegal-command flag.

Function
REQ-014 A command SHALL be accepted only in a cycle where i_cmd_valid and o_cmd_ready are both high; it SHALL have no effect otherwise.
REQ-015 The FSM SHALL have states LOAD, PROC and OUT; all outputs SHALL be registered.
REQ-016 o_cmd_ready SHALL be low while in PROC and low for exactly the one cycle after any accepted command; it SHALL be high otherwise.
REQ-017 Accepted BLK in LOAD or OUT with o_blk_cnt < MAX_BLK: o_chblk high in the next cycle only; o_blk_cnt incremented in the same cycle.
REQ-018 Accepted BLK with o_blk_cnt == MAX_BLK: no pulse; o_blk_cnt holds; o_err set.
REQ-019 Accepted RUN in LOAD with o_blk_cnt != 0: next cycle state PROC, o_blk_cnt cleared, PROC timer loaded with PROC_CYC-1.
REQ-020 Accepted RUN in LOAD with o_blk_cnt == 0, or RUN in OUT: o_err set; state unchanged.
REQ-021 In PROC, the timer SHALL decrement each cycle; in the cycle after it reads 0, the state SHALL be OUT. PROC therefore lasts exactly PROC_CYC cycles.
REQ-022 Accepted NEXT in OUT: next cycle state LOAD, o_blk_cnt cleared; NEXT in LOAD sets o_err, no state change.
REQ-023 Accepted CLR: o_err cleared next cycle; no other effect. NOP: no effect (ready still drops for one cycle).
REQ-024 Illegal codes (101, 110, 111) SHALL set o_err with no other effect.
REQ-025 o_chblk SHALL never be high in two consecutive cycles; this guarantees a low cycle between pulses for the downstream edge detector.
REQ-026 An o_chblk pulse and a phase change SHALL never occur in the same cycle.

Reset
REQ-027 While rst is high, independent of clk, the block SHALL drive: state LOAD (o_sop=0, o_eop=0), o_chblk=0, o_blk_cnt=0, o_err=0, o_cmd_ready=0, timer=0.
REQ-028 o_cmd_ready SHALL rise on the first clk edge after rst deasserts.
REQ-029 Reset asserted mid-PROC or mid-pulse SHALL abort immediately to the reset values; no pulse or transition SHALL complete afterwards.

Verification
REQ-030 Reset, then three BLK commands, each presented when ready -> three isolated o_chblk pulses; o_blk_cnt reads 1, 2, 3; {eop,sop}=00; o_err=0.
REQ-031 BLK, then RUN with PROC_CYC=16 -> {eop,sop}=01 for exactly 16 cycles, then 10; o_cmd_ready low throughout PROC; o_blk_cnt=0.
REQ-032 In OUT: BLK, BLK, NEXT -> two o_chblk pulses, then {eop,sop}=00 and o_blk_cnt=0.
REQ-033 RUN right after reset; then code 111; then CLR -> o_err=1 after the first command, stays 1 after the second, state remains LOAD, o_err=0 after CLR.
REQ-034 MAX_BLK=8: nine BLKs in LOAD -> eight pulses, o_blk_cnt=8, o_err=1 after the ninth; i_cmd_valid held high continuously -> accepted every other cycle.
REQ-035 rst asserted at PROC cycle 5 -> outputs take reset values asynchronously; after release, RUN with o_blk_cnt=0 sets o_err.

Source files
------------

// File: rtl/mcu_cmd_seq.sv
// mcu_cmd_seq: host command sequencer for the memory control unit. It walks the
// LOAD -> PROC -> OUT phases, issues o_chblk block-change pulses and flags illegal use.
// Latency: every output is registered, so a command accepted on an edge shows on the outputs after that edge.
// Backpressure: o_cmd_ready is low for all of PROC and for the one cycle after each accepted command.
//
// Ports:
//   clk, rst              - rising-edge clock; asynchronous active-high reset
//   i_cmd_valid, i_cmd    - host command (000 NOP, 001 BLK, 010 RUN, 011 NEXT, 100 CLR)
//   o_cmd_ready           - a command can be accepted this cycle
//   o_eop, o_sop          - phase code {eop,sop}: 00 LOAD, 01 PROC, 10 OUT
//   o_chblk               - one-cycle block-change pulse
//   o_blk_cnt             - blocks accepted in the current phase
//   o_err                 - sticky illegal-command flag, cleared by CLR
module mcu_cmd_seq #(
  parameter int MAX_BLK  = 8,
  parameter int PROC_CYC = 16,
  parameter int CNT_W    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_cmd_valid,
  input  logic [2:0]       i_cmd,
  output logic             o_cmd_ready,
  output logic             o_sop,
  output logic             o_eop,
  output logic             o_chblk,
  output logic [CNT_W-1:0] o_blk_cnt,
  output logic             o_err
);

  // The state encoding is the phase code itself, so o_eop and o_sop come
  // straight from the state flops.
  typedef enum logic [1:0] {
    ST_LOAD = 2'b00,
    ST_PROC = 2'b01,
    ST_OUT  = 2'b10
  } state_t;

  localparam logic [2:0] CMD_NOP  = 3'b000;
  localparam logic [2:0] CMD_BLK  = 3'b001;
  localparam logic [2:0] CMD_RUN  = 3'b010;
  localparam logic [2:0] CMD_NEXT = 3'b011;
  localparam logic [2:0] CMD_CLR  = 3'b100;

  localparam logic [15:0]      TMR_LD  = 16'(PROC_CYC - 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BLK);

  state_t           state_q, state_d;
  logic [15:0]      timer_q, timer_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             chblk_q, chblk_d;
  logic             err_q, err_d;
  logic             rdy_q, rdy_d;
  logic             accept;

  // rdy_q is never high in PROC, so commands are only taken in LOAD or OUT.
  assign accept = i_cmd_valid && rdy_q;

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    cnt_d   = cnt_q;
    chblk_d = 1'b0;
    err_d   = err_q;

    if (state_q == ST_PROC) begin
      // The timer counts PROC_CYC-1 down to 0, so PROC lasts PROC_CYC cycles.
      if (timer_q == 16'd0) begin
        state_d = ST_OUT;
      end else begin
        timer_d = timer_q - 16'd1;
      end
    end else if (accept) begin
      case (i_cmd)
        CMD_NOP: ;
        CMD_BLK: begin
          if (cnt_q < MAX_CNT) begin
            cnt_d   = cnt_q + CNT_W'(1);
            chblk_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
        CMD_RUN: begin
          if (state_q == ST_LOAD && cnt_q != '0) begin
            state_d = ST_PROC;
            cnt_d   = '0;
            timer_d = TMR_LD;
          end else begin
            err_d = 1'b1;
          end
        end
        CMD_NEXT: begin
          if (state_q == ST_OUT) begin
            state_d = ST_LOAD;
            cnt_d   = '0;
          end else begin
            err_d = 1'b1;
          end
        end
        CMD_CLR: err_d = 1'b0;
        default: err_d = 1'b1;
      endcase
    end

    // Dropping ready for the cycle after every accept spaces BLK accepts at least
    // two cycles apart, so o_chblk always has a low cycle between pulses. BLK never
    // changes phase, so a pulse and a phase change never fall in the same cycle.
    rdy_d = (state_d != ST_PROC) && !accept;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_LOAD;
      timer_q <= '0;
      cnt_q   <= '0;
      chblk_q <= 1'b0;
      err_q   <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      cnt_q   <= cnt_d;
      chblk_q <= chblk_d;
      err_q   <= err_d;
      rdy_q   <= rdy_d;
    end
  end

  assign o_sop       = state_q[0];
  assign o_eop       = state_q[1];
  assign o_chblk     = chblk_q;
  assign o_blk_cnt   = cnt_q;
  assign o_err       = err_q;
  assign o_cmd_ready = rdy_q;

endmodule

// File: tb/tb_mcu_cmd_seq.sv
// Testbench for mcu_cmd_seq. Expected o_blk_cnt values for each o_chblk pulse are
// queued when a BLK is issued and checked by a monitor when the pulse appears.
// Phase, error, ready and reset behaviour are checked directly after each command.
module tb_mcu_cmd_seq;

  localparam int MAX_BLK  = 8;
  localparam int PROC_CYC = 16;
  localparam int CNT_W    = 4;

  localparam logic [2:0] C_NOP  = 3'b000;
  localparam logic [2:0] C_BLK  = 3'b001;
  localparam logic [2:0] C_RUN  = 3'b010;
  localparam logic [2:0] C_NEXT = 3'b011;
  localparam logic [2:0] C_CLR  = 3'b100;
  localparam logic [2:0] C_ILL  = 3'b111;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             i_cmd_valid = 1'b0;
  logic [2:0]       i_cmd = 3'b000;
  logic             o_cmd_ready;
  logic             o_sop;
  logic             o_eop;
  logic             o_chblk;
  logic [CNT_W-1:0] o_blk_cnt;
  logic             o_err;

  int n_vec = 0;
  int n_err = 0;
  logic [CNT_W-1:0] exp_q[$];

  mcu_cmd_seq #(
    .MAX_BLK (MAX_BLK),
    .PROC_CYC(PROC_CYC),
    .CNT_W   (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .i_cmd_valid(i_cmd_valid),
    .i_cmd      (i_cmd),
    .o_cmd_ready(o_cmd_ready),
    .o_sop      (o_sop),
    .o_eop      (o_eop),
    .o_chblk    (o_chblk),
    .o_blk_cnt  (o_blk_cnt),
    .o_err      (o_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Called on a negedge; waits (bounded) for ready, presents the command for one
  // cycle and returns on the negedge after the accepting edge.
  task automatic send(input logic [2:0] c);
    int w = 0;
    while (!o_cmd_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!o_cmd_ready) chk("rdy_wait", {31'd0, o_cmd_ready}, 1);
    i_cmd_valid = 1'b1;
    i_cmd       = c;
    @(negedge clk);
    i_cmd_valid = 1'b0;
    i_cmd       = C_NOP;
    chk("rdy_drop", {31'd0, o_cmd_ready}, 0);
  endtask

  // Asserts reset between clock edges and checks the asynchronous reset values.
  task automatic reset_pulse();
    #2 rst = 1'b1;
    #1;
    chk("rst_phase", {30'd0, o_eop, o_sop}, 0);
    chk("rst_chblk", {31'd0, o_chblk}, 0);
    chk("rst_cnt", {28'd0, o_blk_cnt}, 0);
    chk("rst_err", {31'd0, o_err}, 0);
    chk("rst_rdy", {31'd0, o_cmd_ready}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1 chk("rel_rdy_low", {31'd0, o_cmd_ready}, 0);
    @(negedge clk);
    chk("rel_rdy_high", {31'd0, o_cmd_ready}, 1);
  endtask

  // Pulse monitor: pops the expected count for every o_chblk pulse and checks
  // pulse isolation and that no phase change coincides with a pulse.
  logic       prev_chblk = 1'b0;
  logic [1:0] prev_ph = 2'b00;
  always @(negedge clk) begin
    if (rst) begin
      prev_chblk = 1'b0;
      prev_ph    = 2'b00;
    end else begin
      chk("ph_legal", {31'd0, ({o_eop, o_sop} != 2'b11)}, 1);
      if (o_chblk) begin
        chk("chblk_isolated", {31'd0, prev_chblk}, 0);
        chk("chblk_ph_stable", {30'd0, o_eop, o_sop}, {30'd0, prev_ph});
        if (exp_q.size() == 0) chk("chblk_unexpected", {31'd0, o_chblk}, 0);
        else chk("chblk_cnt", {28'd0, o_blk_cnt}, {28'd0, exp_q.pop_front()});
      end
      prev_chblk = o_chblk;
      prev_ph    = {o_eop, o_sop};
    end
  end

  initial begin
    int   n;
    logic any_rdy;

    reset_pulse();

    // Three BLKs in LOAD.
    for (int k = 1; k <= 3; k++) begin
      exp_q.push_back(CNT_W'(k));
      send(C_BLK);
      chk("blk_cnt", {28'd0, o_blk_cnt}, k);
      chk("blk_ph", {30'd0, o_eop, o_sop}, 0);
      chk("blk_err", {31'd0, o_err}, 0);
    end
    @(negedge clk);
    chk("rdy_back", {31'd0, o_cmd_ready}, 1);

    // RUN: PROC for exactly PROC_CYC cycles, ready low, count cleared.
    send(C_RUN);
    chk("run_cnt", {28'd0, o_blk_cnt}, 0);
    n = 0;
    any_rdy = 1'b0;
    for (int i = 0; i < 100 && {o_eop, o_sop} == 2'b01; i++) begin
      n++;
      if (o_cmd_ready) any_rdy = 1'b1;
      @(negedge clk);
    end
    chk("proc_len", n, PROC_CYC);
    chk("proc_rdy_low", {31'd0, any_rdy}, 0);
    chk("out_ph", {30'd0, o_eop, o_sop}, 2'b10);
    chk("out_rdy", {31'd0, o_cmd_ready}, 1);

    // OUT: BLK, BLK, RUN (illegal here), CLR, NEXT.
    exp_q.push_back(CNT_W'(1));
    send(C_BLK);
    exp_q.push_back(CNT_W'(2));
    send(C_BLK);
    chk("out_cnt", {28'd0, o_blk_cnt}, 2);
    send(C_RUN);
    chk("out_run_err", {31'd0, o_err}, 1);
    chk("out_run_ph", {30'd0, o_eop, o_sop}, 2'b10);
    send(C_CLR);
    chk("out_clr", {31'd0, o_err}, 0);
    send(C_NEXT);
    chk("next_ph", {30'd0, o_eop, o_sop}, 0);
    chk("next_cnt", {28'd0, o_blk_cnt}, 0);
    send(C_NEXT);
    chk("load_next_err", {31'd0, o_err}, 1);
    chk("load_next_ph", {30'd0, o_eop, o_sop}, 0);
    send(C_NOP);
    chk("nop_err_held", {31'd0, o_err}, 1);

    // Error handling straight after reset.
    reset_pulse();
    send(C_RUN);
    chk("run0_err", {31'd0, o_err}, 1);
    chk("run0_ph", {30'd0, o_eop, o_sop}, 0);
    send(C_ILL);
    chk("ill_err", {31'd0, o_err}, 1);
    chk("ill_ph", {30'd0, o_eop, o_sop}, 0);
    send(C_CLR);
    chk("clr_err", {31'd0, o_err}, 0);
    chk("clr_ph", {30'd0, o_eop, o_sop}, 0);

    // Nine BLKs with valid held high: accepted every other cycle, ninth overflows.
    while (!o_cmd_ready) @(negedge clk);
    for (int k = 1; k <= MAX_BLK; k++) exp_q.push_back(CNT_W'(k));
    i_cmd_valid = 1'b1;
    i_cmd       = C_BLK;
    for (int k = 0; k < 18; k++) begin
      chk("rdy_alt", {31'd0, o_cmd_ready}, (k % 2 == 0) ? 1 : 0);
      @(negedge clk);
    end
    i_cmd_valid = 1'b0;
    i_cmd       = C_NOP;
    chk("max_cnt", {28'd0, o_blk_cnt}, MAX_BLK);
    chk("max_err", {31'd0, o_err}, 1);
    chk("max_pulses", exp_q.size(), 0);

    // Reset in PROC cycle 5 with o_err set.
    send(C_NEXT);
    send(C_RUN);
    chk("mid_ph", {30'd0, o_eop, o_sop}, 2'b01);
    repeat (4) @(negedge clk);
    chk("mid_ph5", {30'd0, o_eop, o_sop}, 2'b01);
    reset_pulse();
    chk("post_ph", {30'd0, o_eop, o_sop}, 0);
    send(C_RUN);
    chk("post_run_err", {31'd0, o_err}, 1);
    chk("post_run_ph", {30'd0, o_eop, o_sop}, 0);

    chk("sb_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
